// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC acquisition sequencer: parameter defaults,
// frame width, sequencer state encoding and a small counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_pkg;

  // Parameter defaults used by the sequencer and its SCK shifter.
  localparam int DEF_CLK_FREQ     = 100_000_000;
  localparam int DEF_SMPL_FREQ    = 48_000;
  localparam int DEF_SCK_HALF     = 12;
  localparam int DEF_CNV_HIGH     = 4;
  localparam int DEF_BUSY_TIMEOUT = 200;

  // Bits per conversion result.
  localparam int FRAME_W = 24;

  // Cycles after CNV falls before a low synchronized BUSY is trusted. This
  // covers the synchronizer latency so a BUSY that has not yet been seen
  // rising is not mistaken for an already finished conversion.
  localparam int BUSY_SETTLE = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONV      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_TICK = 3'd4
  } adc_state_e;

  // Number of bits needed to hold values 0..max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_sck_shifter.sv
// -----------------------------------------------------------------------------
// adc_sck_shifter
// Generates FRAME_W SCK periods (SCK_HALF cycles low, then SCK_HALF cycles
// high) after a start pulse and shifts in SDO MSB first.
//
// Ports:
//   clk      in   system clock
//   i_reset  in   synchronous active-high reset
//   i_start  in   one-cycle pulse, begins a frame (ignored while active)
//   i_sdo    in   ADC serial data
//   o_sck    out  ADC serial clock, low whenever no frame is active
//   o_done   out  one-cycle pulse in the last high cycle of the final SCK
//   o_word   out  assembled word, complete when o_done is high
// -----------------------------------------------------------------------------
module adc_sck_shifter
  import adc_pkg::*;
#(
  parameter int SCK_HALF = DEF_SCK_HALF
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_sdo,
  output logic               o_sck,
  output logic               o_done,
  output logic [FRAME_W-1:0] o_word
);

  localparam int HW = cnt_width(SCK_HALF - 1);
  localparam int BW = cnt_width(FRAME_W - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_W - 1);

  logic               active_q, active_d;
  logic               sck_q, sck_d;
  logic [HW-1:0]      half_q, half_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               half_end;

  assign half_end = active_q && (half_q == HALF_LAST);

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    half_d   = half_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    o_done   = 1'b0;
    if (!active_q) begin
      if (i_start) begin
        active_d = 1'b1;
        sck_d    = 1'b0;
        half_d   = '0;
        bit_d    = '0;
      end
    end else begin
      half_d = half_q + HW'(1);
      if (half_end) begin
        half_d = '0;
        if (!sck_q) begin
          // Capture on the edge that raises SCK: the ADC moves SDO on SCK
          // rising, so this samples the bit it has been holding.
          sck_d = 1'b1;
          sr_d  = {sr_q[FRAME_W-2:0], i_sdo};
        end else begin
          sck_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
            o_done   = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
    end
  end

  assign o_sck  = sck_q;
  assign o_word = sr_q;

endmodule

// File: rtl/adc_acq_sequencer.sv
// -----------------------------------------------------------------------------
// adc_acq_sequencer
// Periodic conversion sequencer for a serial SAR ADC: pulses CNV once per
// sample period, waits for BUSY to fall (with a timeout), reads FRAME_W bits
// through adc_sck_shifter and presents the result on a valid/ready output.
//
// Ports:
//   clk             in   system clock
//   i_reset         in   synchronous active-high reset
//   i_enable        in   run conversions while high
//   i_busy          in   ADC BUSY (asynchronous, synchronized here)
//   i_data_in       in   ADC SDO
//   i_ready         in   consumer accepts o_data_frame
//   i_clear_status  in   one-cycle pulse clearing the sticky flags
//   o_start_conv    out  ADC CNV
//   o_sck           out  ADC SCK
//   o_RDL_SDI       out  tied 0 (normal read mode)
//   o_chain         out  tied 0 (normal mode)
//   o_data_frame    out  last captured sample, MSB = first bit shifted
//   o_valid         out  o_data_frame holds an unaccepted sample
//   o_overrun       out  sticky: sample dropped or sample tick missed
//   o_timeout       out  sticky: BUSY did not fall in time
// -----------------------------------------------------------------------------
module adc_acq_sequencer
  import adc_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int SMPL_FREQ    = DEF_SMPL_FREQ,
  parameter int SCK_HALF     = DEF_SCK_HALF,
  parameter int CNV_HIGH     = DEF_CNV_HIGH,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_busy,
  input  logic               i_data_in,
  input  logic               i_ready,
  input  logic               i_clear_status,
  output logic               o_start_conv,
  output logic               o_sck,
  output logic               o_RDL_SDI,
  output logic               o_chain,
  output logic [FRAME_W-1:0] o_data_frame,
  output logic               o_valid,
  output logic               o_overrun,
  output logic               o_timeout
);

  localparam int PERIOD = CLK_FREQ / SMPL_FREQ;
  localparam int PW     = cnt_width(PERIOD - 1);
  localparam int TW     = cnt_width(BUSY_TIMEOUT + CNV_HIGH + BUSY_SETTLE);

  localparam logic [PW-1:0] PER_LAST   = PW'(PERIOD - 1);
  localparam logic [TW-1:0] CNV_LAST   = TW'(CNV_HIGH - 1);
  localparam logic [TW-1:0] BUSY_EARLY = TW'(CNV_HIGH + BUSY_SETTLE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT - 1);

  adc_state_e         state_q, state_d;
  logic               busy_meta_q, busy_sync_q;
  logic [PW-1:0]      per_q, per_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic               tick;
  logic               busy_ready;
  logic               tmo_hit;
  logic               start_conv;
  logic               shift_start;
  logic               tmo_evt;
  logic               tick_skip;
  logic               drop;

  logic               sh_sck;
  logic               sh_done;
  logic [FRAME_W-1:0] sh_word;

  // ---------------------------------------------------------------------------
  // BUSY synchronizer and sample-period counter
  // ---------------------------------------------------------------------------
  // The counter is held at 0 while disabled, so the cycle i_enable rises is
  // itself a tick and the first conversion starts immediately.
  assign per_d = !i_enable           ? '0 :
                 (per_q == PER_LAST) ? '0 : per_q + PW'(1);
  assign tick  = i_enable && (per_q == '0);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
      per_q       <= '0;
    end else begin
      busy_meta_q <= i_busy;
      busy_sync_q <= busy_meta_q;
      per_q       <= per_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion timer: 0 in the first CNV-high cycle, counts through CONV and
  // WAIT_BUSY. It doubles as CNV width counter and BUSY timeout counter.
  // ---------------------------------------------------------------------------
  assign tmr_d = (state_q == ST_CONV || state_q == ST_WAIT_BUSY) ?
                 tmr_q + TW'(1) : '0;

  assign busy_ready = !busy_sync_q && (tmr_q >= BUSY_EARLY);
  assign tmo_hit    = (tmr_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (tmr_q == CNV_LAST) state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (busy_ready)   state_d = ST_SHIFT;
        else if (tmo_hit) state_d = ST_WAIT_TICK;
      end
      ST_SHIFT: begin
        if (sh_done) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        // A disable seen mid-frame lands here and drops straight to IDLE.
        if (!i_enable)  state_d = ST_IDLE;
        else if (tick)  state_d = ST_CONV;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    start_conv  = (state_q == ST_CONV);
    shift_start = (state_q == ST_WAIT_BUSY) && busy_ready;
    tmo_evt     = (state_q == ST_WAIT_BUSY) && !busy_ready && tmo_hit;
    tick_skip   = tick && (state_q != ST_IDLE) && (state_q != ST_WAIT_TICK);
  end

  // ---------------------------------------------------------------------------
  // SCK generation and shift register
  // ---------------------------------------------------------------------------
  adc_sck_shifter #(
    .SCK_HALF (SCK_HALF)
  ) u_shifter (
    .clk     (clk),
    .i_reset (i_reset),
    .i_start (shift_start),
    .i_sdo   (i_data_in),
    .o_sck   (sh_sck),
    .o_done  (sh_done),
    .o_word  (sh_word)
  );

  // ---------------------------------------------------------------------------
  // Output frame and sticky status.
  // Handshake: a sample transfers in every cycle where o_valid and i_ready are
  // both high; o_valid then drops the following cycle unless a new frame
  // completes in that same transfer cycle, in which case it loads and o_valid
  // stays high. o_data_frame never changes while o_valid is high except on a
  // transfer. A frame completing with o_valid high and i_ready low is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_d = frame_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (sh_done) begin
      if (!valid_q || i_ready) begin
        frame_d = sh_word;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    // A set event in the clear cycle wins.
    if (drop || tick_skip)   overrun_d = 1'b1;
    else if (i_clear_status) overrun_d = 1'b0;
    else                     overrun_d = overrun_q;

    if (tmo_evt)             timeout_d = 1'b1;
    else if (i_clear_status) timeout_d = 1'b0;
    else                     timeout_d = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      frame_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_start_conv = start_conv;
  assign o_sck        = sh_sck;
  assign o_RDL_SDI    = 1'b0;
  assign o_chain      = 1'b0;
  assign o_data_frame = frame_q;
  assign o_valid      = valid_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule
